// File: rtl/inc_pipe_pkg.sv
// Shared types for the inc_pipe incrementer/decrementer pipeline.
// Optional macro INC_PIPE_SAT_EN (see inc_pipe.sv) enables saturating results.
package inc_pipe_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        SPEED_SLOW   = 2'd0,
        SPEED_MEDIUM = 2'd1,
        SPEED_FAST   = 2'd2
    } speed_e;

    // Stage payload; z is sized for the widest legal operand, low WIDTH bits used.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] z;
        logic                 co;
    } stage_t;

endpackage

// File: rtl/PrefixAnd.sv
// Prefix-AND network: y_o[i] = &a_i[i:0].
// SPEED selects serial, Brent-Kung or Sklansky structure.
module PrefixAnd
    import inc_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned SPEED = 1
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] y_o
);

    localparam int W      = int'(WIDTH);
    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    always_comb begin
        logic [WIDTH-1:0] t;
        t = a_i;
        if (SPEED == 32'(SPEED_SLOW)) begin
            for (int i = 1; i < W; i++) begin
                t[i] = t[i] & t[i-1];
            end
        end else if (SPEED == 32'(SPEED_FAST)) begin
            // Sklansky: at level k every bit with index bit k set joins its block's top-of-lower-half.
            for (int k = 0; k < LEVELS; k++) begin
                for (int i = 0; i < W; i++) begin
                    if (((i >> k) & 1) == 1) begin
                        t[i] = t[i] & t[((i >> k) << k) - 1];
                    end
                end
            end
        end else begin
            // Brent-Kung up-sweep builds block prefixes, down-sweep fills the gaps.
            for (int k = 0; k < LEVELS; k++) begin
                for (int i = 0; i < W; i++) begin
                    if (((i + 1) % (1 << (k + 1))) == 0) begin
                        t[i] = t[i] & t[i - (1 << k)];
                    end
                end
            end
            for (int k = LEVELS - 1; k >= 0; k--) begin
                for (int i = 0; i < W; i++) begin
                    if ((((i + 1) % (1 << (k + 1))) == (1 << k)) && ((i + 1) > (1 << (k + 1)))) begin
                        t[i] = t[i] & t[i - (1 << k)];
                    end
                end
            end
        end
        y_o = t;
    end

endmodule

// File: rtl/inc_pipe.sv
// Pipelined incrementer/decrementer with valid/ready handshake and flush.
// Define INC_PIPE_SAT_EN to saturate on overflow/underflow instead of wrapping.
module inc_pipe
    import inc_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SPEED  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic             ci_i,
    input  logic             dec_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] z_o,
    output logic             co_o
);

    localparam int unsigned PW   = WIDTH + 1;
    localparam int unsigned LAST = STAGES - 1;

    logic [WIDTH-1:0]  opnd;
    logic [WIDTH-1:0]  sum;
    logic [WIDTH-1:0]  res_z;
    logic              res_co;
    logic [PW-1:0]     pa_in;
    logic [PW-1:0]     pa_out;
    stage_t            res;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] adv;
    stage_t            pipe_q [STAGES];
    logic              accept;
    logic              unused_hi;

    // Decrement reuses the increment carry path: a - ci == ~(~a + ci).
    assign opnd  = dec_i ? ~a_i : a_i;
    assign pa_in = {opnd, ci_i};

    PrefixAnd #(
        .WIDTH(PW),
        .SPEED(SPEED)
    ) u_prefix (
        .a_i(pa_in),
        .y_o(pa_out)
    );

    always_comb begin
        sum    = opnd ^ pa_out[WIDTH-1:0];
        res_co = pa_out[WIDTH];
        res_z  = dec_i ? ~sum : sum;
`ifdef INC_PIPE_SAT_EN
        if (res_co) begin
            res_z = dec_i ? '0 : '1;
        end
`endif
        res               = '0;
        res.z[WIDTH-1:0]  = res_z;
        res.co            = res_co;
    end

    // A stage may advance when it or any stage downstream of it has a free slot.
    always_comb begin
        logic run;
        run = out_ready_i;
        adv = '0;
        for (int s = int'(LAST); s >= 0; s--) begin
            run    = run | ~valid_q[s];
            adv[s] = run;
        end
    end

    assign in_ready_o = adv[0] & ~flush_i;
    assign accept     = in_valid_i & in_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int s = 0; s < int'(STAGES); s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            if (flush_i) begin
                valid_q <= '0;
            end else begin
                if (adv[0]) begin
                    valid_q[0] <= accept;
                end
                for (int s = 1; s < int'(STAGES); s++) begin
                    if (adv[s]) begin
                        valid_q[s] <= valid_q[s-1];
                    end
                end
            end
            if (accept) begin
                pipe_q[0] <= res;
            end
            for (int s = 1; s < int'(STAGES); s++) begin
                if (adv[s]) begin
                    pipe_q[s] <= pipe_q[s-1];
                end
            end
        end
    end

    assign out_valid_o = valid_q[LAST];
    assign z_o         = pipe_q[LAST].z[WIDTH-1:0];
    assign co_o        = pipe_q[LAST].co;
    assign unused_hi   = ^pipe_q[LAST].z;

endmodule

// File: tb/tb_inc_pipe.sv
// Directed and randomized checks of inc_pipe (WIDTH=8, STAGES=2) across SPEED 0/1/2.
module tb_inc_pipe;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 2;

`ifdef INC_PIPE_SAT_EN
    localparam logic [7:0] EXP_INC_FF = 8'hFF;
    localparam logic [7:0] EXP_DEC_00 = 8'h00;
`else
    localparam logic [7:0] EXP_INC_FF = 8'h00;
    localparam logic [7:0] EXP_DEC_00 = 8'hFF;
`endif

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] a;
    logic       ci;
    logic       dec;
    logic       out_ready;

    logic       in_ready,  out_valid,  co;
    logic [7:0] z;
    logic       in_ready0, out_valid0, co0;
    logic [7:0] z0;
    logic       in_ready2, out_valid2, co2;
    logic [7:0] z2;

    int vectors = 0;
    int errors  = 0;

    inc_pipe #(.WIDTH(WIDTH), .SPEED(1), .STAGES(STAGES)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .ci_i(ci), .dec_i(dec),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .z_o(z), .co_o(co)
    );

    inc_pipe #(.WIDTH(WIDTH), .SPEED(0), .STAGES(STAGES)) u_dut_s0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready0),
        .a_i(a), .ci_i(ci), .dec_i(dec),
        .out_valid_o(out_valid0), .out_ready_i(out_ready),
        .z_o(z0), .co_o(co0)
    );

    inc_pipe #(.WIDTH(WIDTH), .SPEED(2), .STAGES(STAGES)) u_dut_s2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .a_i(a), .ci_i(ci), .dec_i(dec),
        .out_valid_o(out_valid2), .out_ready_i(out_ready),
        .z_o(z2), .co_o(co2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] model(input logic [7:0] av, input logic civ, input logic decv);
        logic [7:0] zz;
        logic       cc;
        if (!decv) begin
            {cc, zz} = 9'(av) + 9'(civ);
        end else begin
            zz = av - 8'(civ);
            cc = (av == 8'h00) && civ;
        end
`ifdef INC_PIPE_SAT_EN
        if (cc) zz = decv ? 8'h00 : 8'hFF;
`endif
        return {cc, zz};
    endfunction

    task automatic test_reset();
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; a = '0; ci = 1'b0; dec = 1'b0; out_ready = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        vectors++;
        if ({co, z} !== 9'h000) begin errors++; $display("FAIL reset_data: got %h expected 000", {co, z}); end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single(input string name, input logic [7:0] av, input logic civ,
                               input logic decv, input logic [7:0] ez, input logic eco);
        in_valid = 1'b1; a = av; ci = civ; dec = decv;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b expected 1", name, in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early: valid got %b expected 0", name, out_valid); end
        tick();
        vectors++;
        if ({out_valid, co, z} !== {1'b1, eco, ez}) begin
            errors++;
            $display("FAIL %s: {valid,co,z} got %b,%b,%h expected 1,%b,%h", name, out_valid, co, z, eco, ez);
        end
        tick();
    endtask

    task automatic test_stream();
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc < 10) begin
                in_valid = 1'b1; a = 8'(cyc); ci = 1'b1; dec = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc < 10) begin
                vectors++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", cyc, in_ready); end
            end
            tick();
            vectors++;
            if (cyc >= 1 && cyc <= 10) begin
                if ({out_valid, co, z} !== {1'b1, 1'b0, 8'(cyc)}) begin
                    errors++;
                    $display("FAIL stream_out[%0d]: valid,co,z got %b,%b,%h expected 1,0,%h", cyc, out_valid, co, z, 8'(cyc));
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_idle[%0d]: valid got %b expected 0", cyc, out_valid);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] q[$];
        int         acc;
        logic       exp_rdy;
        acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; a = 8'h20 + 8'(acc); ci = 1'b1; dec = 1'b0;
            #1;
            exp_rdy = (acc < int'(STAGES));
            vectors++;
            if (in_ready !== exp_rdy) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected %b", c, in_ready, exp_rdy); end
            if (exp_rdy) begin
                q.push_back(a + 8'h01);
                acc++;
            end
            tick();
            if (c >= 1) begin
                vectors++;
                if ({out_valid, co, z} !== {1'b1, 1'b0, 8'h21}) begin
                    errors++;
                    $display("FAIL bp_hold[%0d]: valid,co,z got %b,%b,%h expected 1,0,21", c, out_valid, co, z);
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                vectors++;
                if (z !== q[0]) begin errors++; $display("FAIL bp_drain: z got %h expected %h", z, q[0]); end
                void'(q.pop_front());
            end
            tick();
        end
        vectors++;
        if (q.size() != 0) begin errors++; $display("FAIL bp_lost: %0d items left, expected 0", q.size()); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_valid = 1'b1; a = 8'h40; ci = 1'b1; dec = 1'b0;
        tick();
        a = 8'h41;
        tick();
        flush = 1'b1; a = 8'h77;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak: got %b expected 0", out_valid); end
        test_single("flush_after", 8'h05, 1'b1, 1'b0, 8'h06, 1'b0);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; a = 8'h30; ci = 1'b1; dec = 1'b0;
        tick();
        a = 8'h31;
        tick();
        vectors++;
        if ({out_valid, z} !== {1'b1, 8'h31}) begin errors++; $display("FAIL arst_pre: valid,z got %b,%h expected 1,31", out_valid, z); end
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        vectors++;
        if ({out_valid, co, z} !== 10'h000) begin
            errors++;
            $display("FAIL arst_now: valid,co,z got %b,%b,%h expected 0,0,00", out_valid, co, z);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL arst_after: ready,valid got %b,%b expected 1,0", in_ready, out_valid); end
    endtask

    task automatic test_random();
        logic [8:0] sb[$];
        logic [8:0] exp;
        for (int c = 0; c < 80; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            a         = 8'($urandom);
            ci        = 1'($urandom_range(1));
            dec       = 1'($urandom_range(1));
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious[%0d]: got %b,%h expected no output", c, co, z);
                end else begin
                    exp = sb.pop_front();
                    if ({co, z} !== exp || {co0, z0} !== exp || {co2, z2} !== exp) begin
                        errors++;
                        $display("FAIL rand[%0d]: s1=%h s0=%h s2=%h expected %h", c, {co, z}, {co0, z0}, {co2, z2}, exp);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(a, ci, dec));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                exp = sb.pop_front();
                vectors++;
                if ({co, z} !== exp || {co0, z0} !== exp || {co2, z2} !== exp) begin
                    errors++;
                    $display("FAIL rand_drain: s1=%h s0=%h s2=%h expected %h", {co, z}, {co0, z0}, {co2, z2}, exp);
                end
            end
            tick();
        end
        vectors++;
        if (sb.size() != 0) begin errors++; $display("FAIL rand_lost: %0d items left, expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single("inc_ff",  8'hFF, 1'b1, 1'b0, EXP_INC_FF, 1'b1);
        test_single("dec_00",  8'h00, 1'b1, 1'b1, EXP_DEC_00, 1'b1);
        test_single("dec_10",  8'h10, 1'b1, 1'b1, 8'h0F, 1'b0);
        test_single("inc_ci0", 8'h33, 1'b0, 1'b0, 8'h33, 1'b0);
        test_single("dec_ci0", 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        test_single("inc_7f",  8'h7F, 1'b1, 1'b0, 8'h80, 1'b0);
        test_single("dec_80",  8'h80, 1'b1, 1'b1, 8'h7F, 1'b0);
        test_stream();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
